prog_loader: RTL

- Writer side of the 16x8 program store: accepts a program byte stream over a valid/ready handshake and writes it into an internal 16x8 program RAM.
- Exposes a combinational fetch port with the same timing as rom16x8, so program_counter can drive it directly.
- Holds the CPU in reset (CPU_RST) until a full 16-byte image is loaded, then releases it; reports an 8-bit checksum of the loaded image.

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 41 ++++
 rtl/prog_loader_ram16x8.sv | 27 ++
 rtl/prog_loader.sv | 104 ++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared widths, loader state encoding and checksum helper for the 16x8 program store.
package prog_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  // Running image checksum, wraps modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] csum_add(
    input logic [DATA_W-1:0] sum,
    input logic [DATA_W-1:0] data
  );
    return sum + data;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream load handshake, fetch port and loader status bundled for prog_loader.
interface prog_loader_if #(
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
);

  logic              load_start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_rst;
  logic              load_done;
  logic [DATA_W-1:0] checksum;

  modport master (
    output load_start,
    output in_valid,
    output in_data,
    output fetch_addr,
    input  in_ready,
    input  fetch_data,
    input  cpu_rst,
    input  load_done,
    input  checksum
  );

  modport slave (
    input  load_start,
    input  in_valid,
    input  in_data,
    input  fetch_addr,
    output in_ready,
    output fetch_data,
    output cpu_rst,
    output load_done,
    output checksum
  );

endinterface

// File: rtl/prog_loader_ram16x8.sv
// Program RAM: synchronous write, asynchronous read; read side matches rom16x8 timing.
module ram16x8 #(
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset so a partial load survives RST.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_data = r_mem[i_addr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a 16-byte image into ram16x8, holds the CPU in reset until complete.
module prog_loader #(
  parameter int ADDR_W = prog_loader_pkg::ADDR_W,
  parameter int DATA_W = prog_loader_pkg::DATA_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  prog_loader_if.slave bus
);

  import prog_loader_pkg::*;

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [DATA_W-1:0] r_checksum;
  logic              r_cpu_rst;
  logic              r_load_done;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_restart;
  logic              w_we;

  assign w_in_ready = (r_state == LD_LOAD);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last     = (r_wr_ptr == ADDR_W'(MEM_DEPTH - 1));
  assign w_restart  = bus.load_start && ((r_state == LD_IDLE) || (r_state == LD_DONE));
  assign w_we       = w_accept && !i_rst;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LD_IDLE: begin
        if (bus.load_start) begin
          w_state_nxt = LD_LOAD;
        end else begin
          w_state_nxt = LD_IDLE;
        end
      end
      LD_LOAD: begin
        if (w_accept && w_last) begin
          w_state_nxt = LD_DONE;
        end else begin
          w_state_nxt = LD_LOAD;
        end
      end
      LD_DONE: begin
        if (bus.load_start) begin
          w_state_nxt = LD_LOAD;
        end else begin
          w_state_nxt = LD_DONE;
        end
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they move on the edge entering DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= LD_IDLE;
      r_wr_ptr    <= {ADDR_W{1'b0}};
      r_checksum  <= {DATA_W{1'b0}};
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst   <= (w_state_nxt != LD_DONE);
      r_load_done <= (w_state_nxt == LD_DONE);
      if (w_restart) begin
        r_wr_ptr   <= {ADDR_W{1'b0}};
        r_checksum <= {DATA_W{1'b0}};
      end else if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
        r_checksum <= csum_add(r_checksum, bus.in_data);
      end else begin
        r_wr_ptr   <= r_wr_ptr;
        r_checksum <= r_checksum;
      end
    end
  end

  ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_addr  (bus.fetch_addr),
    .o_data  (bus.fetch_data)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.cpu_rst   = r_cpu_rst;
  assign bus.load_done = r_load_done;
  assign bus.checksum  = r_checksum;

endmodule
